// File: rtl/uart_rx_core.sv
// uart_rx_core
// ------------
// UART receiver for frames of the form: start (0), 8 data bits LSB first,
// one parity bit, one stop (1). The serial line is oversampled with an
// external baud_tick enable that pulses OVS times per bit period. Every
// bit is sampled once, at mid-bit.
//
// Parameters
//   PARITY_ODD : 0 = even parity expected, 1 = odd parity expected
//   OVS        : baud_tick pulses per bit period (even, >= 8)
//
// Ports
//   clk        : system clock, rising-edge
//   rst_n      : asynchronous active-low reset
//   baud_tick  : one-clk enable, OVS x bit rate
//   rx_in      : serial line, idles high, asynchronous to clk
//   rx_data    : last received byte (holds until the next rx_valid)
//   rx_valid   : one-clk pulse in the cycle after the stop sample
//   parity_err : parity mismatch for the frame marked by rx_valid
//   frame_err  : stop bit sampled low for the frame marked by rx_valid
//   rx_busy    : high whenever the receiver is not idle
module uart_rx_core #(
    parameter int PARITY_ODD = 0,
    parameter int OVS        = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       baud_tick,
    input  logic       rx_in,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       parity_err,
    output logic       frame_err,
    output logic       rx_busy
);

    localparam int            CW       = $clog2(OVS);
    localparam logic [CW-1:0] CNT_LAST = CW'(OVS - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(OVS / 2 - 1);
    localparam logic          ODD_BIT  = (PARITY_ODD != 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    // Two-flop synchronizer; flops reset high so reset looks like an idle line.
    logic sync1_q, sync2_q;
    logic rxs;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    shift_q, shift_d;
    logic          par_q, par_d;
    // Set once the line has been seen high on a baud_tick; a start is only
    // accepted while this is set, so a break or reset must be followed by
    // an idle-high period before the next frame.
    logic          seen_high_q, seen_high_d;
    logic [7:0]    rx_data_q, rx_data_d;
    logic          valid_q, valid_d;
    logic          perr_q, perr_d;
    logic          ferr_q, ferr_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= rx_in;
            sync2_q <= sync1_q;
        end
    end

    assign rxs = sync2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            shift_q     <= '0;
            par_q       <= 1'b0;
            seen_high_q <= 1'b0;
            rx_data_q   <= '0;
            valid_q     <= 1'b0;
            perr_q      <= 1'b0;
            ferr_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            shift_q     <= shift_d;
            par_q       <= par_d;
            seen_high_q <= seen_high_d;
            rx_data_q   <= rx_data_d;
            valid_q     <= valid_d;
            perr_q      <= perr_d;
            ferr_q      <= ferr_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        shift_d     = shift_q;
        par_d       = par_q;
        seen_high_d = seen_high_q;
        rx_data_d   = rx_data_q;
        valid_d     = 1'b0;
        perr_d      = perr_q;
        ferr_d      = ferr_q;

        // Every transition is qualified by baud_tick, so the whole FSM
        // freezes while the tick is held low.
        if (baud_tick) begin
            unique case (state_q)
                S_IDLE: begin
                    if (rxs) begin
                        seen_high_d = 1'b1;
                    end else if (seen_high_q) begin
                        state_d     = S_START;
                        cnt_d       = '0;
                        seen_high_d = 1'b0;
                    end
                end

                S_START: begin
                    if (cnt_q == CNT_HALF) begin
                        cnt_d = '0;
                        if (!rxs) begin
                            state_d = S_DATA;
                            idx_d   = '0;
                        end else begin
                            // Glitch, not a start bit: the line is high
                            // on this tick, so it counts as seen high.
                            state_d     = S_IDLE;
                            seen_high_d = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end

                S_DATA: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d          = '0;
                        shift_d[idx_q] = rxs;
                        if (idx_q == 3'd7) begin
                            state_d = S_PARITY;
                            idx_d   = '0;
                        end else begin
                            idx_d = idx_q + 3'd1;
                        end
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end

                S_PARITY: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        par_d   = rxs;
                        state_d = S_STOP;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end

                S_STOP: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d     = '0;
                        state_d   = S_IDLE;
                        valid_d   = 1'b1;
                        rx_data_d = shift_q;
                        perr_d    = (^shift_q) ^ par_q ^ ODD_BIT;
                        ferr_d    = ~rxs;
                        // A high stop bit lets a start edge right after it
                        // be taken immediately; a low one (break) does not.
                        seen_high_d = rxs;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end

                default: begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    assign rx_data    = rx_data_q;
    assign rx_valid   = valid_q;
    assign parity_err = perr_q;
    assign frame_err  = ferr_q;
    assign rx_busy    = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed testbench for uart_rx_core. Two instances share the serial line:
// dut0 expects even parity, dut1 expects odd parity.
module tb_uart_rx_core;

    localparam int OVS      = 16;
    localparam int DIV      = 4;
    localparam int BIT_CLKS = OVS * DIV;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx_in;
    logic       tick_en;
    logic [1:0] div_q = '0;
    logic       baud_tick;

    logic [7:0] rx_data0, rx_data1;
    logic       rx_valid0, rx_valid1;
    logic       parity_err0, parity_err1;
    logic       frame_err0, frame_err1;
    logic       rx_busy0, rx_busy1;

    int checks   = 0;
    int failures = 0;

    int          vcnt0       = 0;
    int          vcnt1       = 0;
    int          busy_cycles = 0;
    logic        last_perr1  = 1'b0;
    logic [9:0]  hist0[$];

    logic        frz_busy;
    int          frz_vcnt;

    always #5 clk = ~clk;

    always @(posedge clk) div_q <= div_q + 2'd1;
    assign baud_tick = tick_en && (div_q == 2'd3);

    uart_rx_core #(.PARITY_ODD(0), .OVS(OVS)) dut0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .baud_tick (baud_tick),
        .rx_in     (rx_in),
        .rx_data   (rx_data0),
        .rx_valid  (rx_valid0),
        .parity_err(parity_err0),
        .frame_err (frame_err0),
        .rx_busy   (rx_busy0)
    );

    uart_rx_core #(.PARITY_ODD(1), .OVS(OVS)) dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .baud_tick (baud_tick),
        .rx_in     (rx_in),
        .rx_data   (rx_data1),
        .rx_valid  (rx_valid1),
        .parity_err(parity_err1),
        .frame_err (frame_err1),
        .rx_busy   (rx_busy1)
    );

    // Monitor: counts valid pulses (a pulse wider than one clk counts twice)
    // and records {frame_err, parity_err, rx_data} at each pulse.
    always @(negedge clk) begin
        if (rx_busy0) busy_cycles <= busy_cycles + 1;
        if (rx_valid0) begin
            vcnt0 <= vcnt0 + 1;
            hist0.push_back({frame_err0, parity_err0, rx_data0});
        end
        if (rx_valid1) begin
            vcnt1      <= vcnt1 + 1;
            last_perr1 <= parity_err1;
        end
    end

    task automatic send_bit(input logic b);
        rx_in = b;
        repeat (BIT_CLKS) @(negedge clk);
    endtask

    task automatic idle_bits(input int n);
        rx_in = 1'b1;
        repeat (n * BIT_CLKS) @(negedge clk);
    endtask

    // Sends one frame; if freeze_bit >= 0, baud_tick is stopped for 300 clks
    // in the middle of that bit (line held steady meanwhile).
    task automatic send_frame(input logic [7:0] d, input logic p, input logic s,
                              input int freeze_bit);
        logic [10:0] bits;
        bits = {s, p, d, 1'b0};
        for (int i = 0; i < 11; i++) begin
            if (i == freeze_bit) begin
                rx_in = bits[i];
                repeat (BIT_CLKS / 2) @(negedge clk);
                tick_en = 1'b0;
                repeat (300) @(negedge clk);
                frz_busy = rx_busy0;
                frz_vcnt = vcnt0;
                tick_en  = 1'b1;
                repeat (BIT_CLKS / 2) @(negedge clk);
            end else begin
                send_bit(bits[i]);
            end
        end
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        rx_in   = 1'b1;
        tick_en = 1'b1;
        repeat (5) @(negedge clk);
        checks++; if (rx_data0 !== 8'h00) begin failures++; $display("FAIL reset_data got=%h exp=00", rx_data0); end
        checks++; if (rx_valid0 !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", rx_valid0); end
        checks++; if (parity_err0 !== 1'b0) begin failures++; $display("FAIL reset_perr got=%b exp=0", parity_err0); end
        checks++; if (frame_err0 !== 1'b0) begin failures++; $display("FAIL reset_ferr got=%b exp=0", frame_err0); end
        checks++; if (rx_busy0 !== 1'b0 || rx_busy1 !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b%b exp=00", rx_busy0, rx_busy1); end
        rst_n = 1'b1;
        idle_bits(2);
        $display("reset: data=%h valid=%b busy=%b", rx_data0, rx_valid0, rx_busy0);
    endtask

    task automatic test_basic();
        int v0;
        v0 = vcnt0;
        send_frame(8'hA5, 1'b0, 1'b1, -1);
        idle_bits(1);
        $display("frame A5: valids=%0d data=%h perr=%b ferr=%b", vcnt0 - v0, rx_data0, parity_err0, frame_err0);
        checks++; if (vcnt0 - v0 !== 1) begin failures++; $display("FAIL a5_valid_count got=%0d exp=1", vcnt0 - v0); end
        checks++; if (rx_data0 !== 8'hA5) begin failures++; $display("FAIL a5_data got=%h exp=a5", rx_data0); end
        checks++; if (parity_err0 !== 1'b0) begin failures++; $display("FAIL a5_perr got=%b exp=0", parity_err0); end
        checks++; if (frame_err0 !== 1'b0) begin failures++; $display("FAIL a5_ferr got=%b exp=0", frame_err0); end
    endtask

    task automatic test_parity();
        int v0, v1;
        v0 = vcnt0;
        v1 = vcnt1;
        send_frame(8'h3C, 1'b1, 1'b1, -1);
        idle_bits(1);
        $display("frame 3C par=1: even perr=%b odd perr=%b data=%h", parity_err0, last_perr1, rx_data0);
        checks++; if (vcnt0 - v0 !== 1) begin failures++; $display("FAIL par_valid_count got=%0d exp=1", vcnt0 - v0); end
        checks++; if (rx_data0 !== 8'h3C) begin failures++; $display("FAIL par_data got=%h exp=3c", rx_data0); end
        checks++; if (parity_err0 !== 1'b1) begin failures++; $display("FAIL par_even_perr got=%b exp=1", parity_err0); end
        checks++; if (frame_err0 !== 1'b0) begin failures++; $display("FAIL par_ferr got=%b exp=0", frame_err0); end
        checks++; if (vcnt1 - v1 !== 1) begin failures++; $display("FAIL par_odd_valid_count got=%0d exp=1", vcnt1 - v1); end
        checks++; if (last_perr1 !== 1'b0) begin failures++; $display("FAIL par_odd_perr got=%b exp=0", last_perr1); end
        checks++; if (rx_data1 !== 8'h3C || frame_err1 !== 1'b0) begin failures++; $display("FAIL par_odd_data got=%h/%b exp=3c/0", rx_data1, frame_err1); end
    endtask

    task automatic test_break();
        int v0, b0;
        v0 = vcnt0;
        send_frame(8'h81, 1'b0, 1'b0, -1);
        checks++; if (vcnt0 - v0 !== 1) begin failures++; $display("FAIL brk_valid_count got=%0d exp=1", vcnt0 - v0); end
        checks++; if (rx_data0 !== 8'h81) begin failures++; $display("FAIL brk_data got=%h exp=81", rx_data0); end
        checks++; if (frame_err0 !== 1'b1) begin failures++; $display("FAIL brk_ferr got=%b exp=1", frame_err0); end
        checks++; if (parity_err0 !== 1'b0) begin failures++; $display("FAIL brk_perr got=%b exp=0", parity_err0); end
        b0 = busy_cycles;
        rx_in = 1'b0;
        repeat (20 * BIT_CLKS) @(negedge clk);
        checks++; if (busy_cycles - b0 !== 0) begin failures++; $display("FAIL brk_hold_busy got=%0d exp=0", busy_cycles - b0); end
        checks++; if (vcnt0 - v0 !== 1) begin failures++; $display("FAIL brk_hold_valid got=%0d exp=1", vcnt0 - v0); end
        idle_bits(3);
        checks++; if (vcnt0 - v0 !== 1) begin failures++; $display("FAIL brk_release_valid got=%0d exp=1", vcnt0 - v0); end
        $display("frame 81 stop=0 + break: valids=%0d ferr=%b", vcnt0 - v0, frame_err0);
    endtask

    task automatic test_glitch();
        int v0, b0;
        v0 = vcnt0;
        b0 = busy_cycles;
        rx_in = 1'b0;
        repeat ((OVS / 4) * DIV) @(negedge clk);
        idle_bits(3);
        $display("glitch: busy_cycles=%0d valids=%0d data=%h", busy_cycles - b0, vcnt0 - v0, rx_data0);
        checks++; if (busy_cycles - b0 <= 0) begin failures++; $display("FAIL glitch_busy got=%0d exp>0", busy_cycles - b0); end
        checks++; if (vcnt0 - v0 !== 0) begin failures++; $display("FAIL glitch_valid got=%0d exp=0", vcnt0 - v0); end
        checks++; if (rx_data0 !== 8'h81) begin failures++; $display("FAIL glitch_data got=%h exp=81", rx_data0); end
    endtask

    task automatic test_freeze();
        int v0;
        v0 = vcnt0;
        send_frame(8'h6B, 1'b1, 1'b1, 3);
        idle_bits(1);
        $display("frame 6B frozen mid-bit: busy=%b valids=%0d data=%h", frz_busy, vcnt0 - v0, rx_data0);
        checks++; if (frz_busy !== 1'b1) begin failures++; $display("FAIL frz_busy got=%b exp=1", frz_busy); end
        checks++; if (frz_vcnt - v0 !== 0) begin failures++; $display("FAIL frz_valid_during got=%0d exp=0", frz_vcnt - v0); end
        checks++; if (vcnt0 - v0 !== 1) begin failures++; $display("FAIL frz_valid_count got=%0d exp=1", vcnt0 - v0); end
        checks++; if (rx_data0 !== 8'h6B) begin failures++; $display("FAIL frz_data got=%h exp=6b", rx_data0); end
        checks++; if (parity_err0 !== 1'b0) begin failures++; $display("FAIL frz_perr got=%b exp=0", parity_err0); end
    endtask

    task automatic test_back_to_back();
        int v0;
        logic [9:0] e0, e1;
        v0 = vcnt0;
        send_frame(8'h00, 1'b0, 1'b1, -1);
        send_frame(8'hFF, 1'b0, 1'b1, -1);
        idle_bits(1);
        e0 = (hist0.size() > v0)     ? hist0[v0]     : 10'bx;
        e1 = (hist0.size() > v0 + 1) ? hist0[v0 + 1] : 10'bx;
        $display("frames 00,FF back-to-back: valids=%0d first=%h second=%h", vcnt0 - v0, e0, e1);
        checks++; if (vcnt0 - v0 !== 2) begin failures++; $display("FAIL b2b_valid_count got=%0d exp=2", vcnt0 - v0); end
        checks++; if (e0 !== 10'h000) begin failures++; $display("FAIL b2b_first got=%h exp=000", e0); end
        checks++; if (e1 !== 10'h0FF) begin failures++; $display("FAIL b2b_second got=%h exp=0ff", e1); end
    endtask

    task automatic test_reset_midframe();
        int v0;
        logic [7:0] d;
        d  = 8'h55;
        v0 = vcnt0;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(d[i]);
        rx_in = d[4];
        repeat (BIT_CLKS / 2) @(negedge clk);
        rst_n = 1'b0;
        repeat (10) @(negedge clk);
        checks++; if (rx_data0 !== 8'h00) begin failures++; $display("FAIL rstmid_data got=%h exp=00", rx_data0); end
        checks++; if (rx_busy0 !== 1'b0) begin failures++; $display("FAIL rstmid_busy got=%b exp=0", rx_busy0); end
        rst_n = 1'b1;
        repeat (BIT_CLKS / 2) @(negedge clk);
        idle_bits(2);
        checks++; if (vcnt0 - v0 !== 0) begin failures++; $display("FAIL rstmid_aborted got=%0d exp=0", vcnt0 - v0); end
        send_frame(8'h96, 1'b0, 1'b1, -1);
        idle_bits(1);
        $display("reset in 55, then frame 96: valids=%0d data=%h", vcnt0 - v0, rx_data0);
        checks++; if (vcnt0 - v0 !== 1) begin failures++; $display("FAIL rstmid_valid_count got=%0d exp=1", vcnt0 - v0); end
        checks++; if (rx_data0 !== 8'h96) begin failures++; $display("FAIL rstmid_data96 got=%h exp=96", rx_data0); end
        checks++; if (parity_err0 !== 1'b0 || frame_err0 !== 1'b0) begin failures++; $display("FAIL rstmid_flags got=%b%b exp=00", parity_err0, frame_err0); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_parity();
        test_break();
        test_glitch();
        test_freeze();
        test_back_to_back();
        test_reset_midframe();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_rx_core.md
UART_RX_CORE -- requirements
Module: uart_rx_core

Interface
REQ-001 Parameter PARITY_ODD, default 0, meaning 0 = even parity expected, 1 = odd parity expected.
REQ-002 Parameter OVS, default 16, meaning baud_tick pulses per bit period; SHALL be even and at least 8.
REQ-003 Port clk, input, 1, system clock; all state updates occur on the rising edge.
REQ-004 Port rst_n, input, 1, reset; asynchronous, active-low.
REQ-005 Port baud_tick, input, 1, single-clk enable pulse at OVS times the bit rate.
REQ-006 Port rx_in, input, 1, serial line; idles high; asynchronous to clk.
REQ-007 Port rx_data, output, 8, last received data byte.
REQ-008 Port rx_valid, output, 1, one-clk pulse marking the end of a frame.
REQ-009 Port parity_err, output, 1, parity mismatch flag for the frame flagged by rx_valid.
REQ-010 Port frame_err, output, 1, stop bit sampled low for the frame flagged by rx_valid.
REQ-011 Port rx_busy, output, 1, high while the state is not IDLE.

Function
REQ-012 Frame format SHALL be start bit (0), 8 data bits LSB first, 1 parity bit, 1 stop bit (1).
REQ-013 rx_in SHALL pass through a 2-flop synchronizer; all logic SHALL use only the synchronized value rxs.
REQ-014 The FSM SHALL have the states IDLE, START, DATA, PARITY and STOP, with a tick counter cnt (0..OVS-1) and a bit index idx (0..7).
REQ-015 IDLE: when rxs=0 and the line has been seen high since the last frame, go to START with cnt=0.
REQ-016 START: advance cnt on each baud_tick; at cnt=OVS/2-1, if rxs=0 go to DATA with cnt=0 and idx=0, else go to IDLE (false start; no output change).
REQ-017 DATA: on the baud_tick where cnt=OVS-1, shift rxs into bit idx and clear cnt; after idx=7 go to PARITY.
REQ-018 PARITY: on the baud_tick where cnt=OVS-1, capture the parity bit and go to STOP.
REQ-019 STOP: on the baud_tick where cnt=OVS-1, sample the stop bit and go to IDLE.
REQ-020 All sampling SHALL occur at mid-bit.
REQ-021 In the clk cycle after the stop sample, rx_valid SHALL be 1 for exactly one clk.
REQ-022 In that same cycle, rx_data, parity_err and frame_err SHALL update and then hold until the next rx_valid.
REQ-023 parity_err SHALL equal (XOR of the 8 data bits XOR the parity bit) XOR PARITY_ODD.
REQ-024 frame_err SHALL equal NOT stop_sample; the data byte SHALL still be delivered with rx_valid=1.
REQ-025 After a stop bit sampled low (break), IDLE SHALL NOT accept a start until rxs has been 1 for at least one baud_tick.
REQ-026 cnt SHALL advance only on baud_tick; with baud_tick held at 0 the FSM SHALL freeze.
REQ-027 Back-to-back frames: a start edge arriving immediately after the stop sample SHALL be detected without loss.
REQ-028 rx_busy SHALL be combinational from the state: 0 in IDLE, 1 in all other states.

Reset
REQ-029 While rst_n=0, the state SHALL be IDLE, cnt=0, idx=0, and the synchronizer flops SHALL be 1.
REQ-030 While rst_n=0, rx_data=8'h00, rx_valid=0, parity_err=0, frame_err=0 and rx_busy=0.
REQ-031 Reset asserted mid-frame SHALL abort the frame with no rx_valid, and the partial data SHALL be discarded.
REQ-032 After reset release, the block SHALL require the line high before accepting a start (same rule as REQ-025).

Verification
REQ-033 Send 0xA5 with parity 0 and stop 1 at PARITY_ODD=0 -> one rx_valid pulse, rx_data=8'hA5, parity_err=0, frame_err=0.
REQ-034 Send 0x3C with parity 1 (wrong for even parity) -> rx_valid, rx_data=8'h3C, parity_err=1, frame_err=0; repeat at PARITY_ODD=1 -> parity_err=0.
REQ-035 Send 0x81 with parity 0 and stop 0, then hold the line low for 20 bit times -> one rx_valid, frame_err=1, and no further rx_valid until the line returns high.
REQ-036 Drive a low glitch of OVS/4 ticks on an idle line -> rx_busy pulses, no rx_valid, and rx_data unchanged.
REQ-037 Send frames 0x00 and 0xFF back-to-back with no idle gap -> two rx_valid pulses, with rx_data 8'h00 then 8'hFF and both error flags 0.
REQ-038 Assert rst_n=0 during data bit 4 of 0x55, release, then send 0x96 -> only one rx_valid, rx_data=8'h96.
